// File: rtl/xpu_mem_pkg.sv
// Shared definitions for the XPU memory arbiter: FSM encoding, default widths
// and the packed-port slicing helper.
package xpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_PORTS   = 2;
  localparam int DEF_ADDR_W      = 64;
  localparam int DEF_DATA_W      = 64;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_CNT_W       = 8;

  // Port k of a packed per-port bus occupies [k*width +: width].
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/xpu_rr_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around, returned one-hot.
module xpu_rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N)) begin
        sum = sum - (PTR_W+1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xpu_mem_arbiter.sv
// N-port round-robin arbiter onto a single memory port with one outstanding
// transaction, per-port response steering and an optional response timeout.
module xpu_mem_arbiter
  import xpu_mem_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS-1:0]        req_wen_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata_i,
  output logic [NUM_PORTS-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic                        rsp_err_o,
  output logic                        mem_req_valid_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic                        mem_wen_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic                        mem_data_valid_i,
  input  logic [DATA_W-1:0]           mem_data_i,
  output logic [NUM_PORTS-1:0]        grant_o
);

  localparam int               PTR_W        = $clog2(NUM_PORTS);
  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  arb_state_e           state_q, state_n;
  logic [PTR_W-1:0]     ptr_q, grant_idx_q, pick_idx, ptr_next;
  logic [NUM_PORTS-1:0] mask_q, grant_q, eligible, pick_oh;
  logic [ADDR_W-1:0]    addr_q, pick_addr;
  logic                 wen_q, pick_wen;
  logic [DATA_W-1:0]    wdata_q, pick_wdata;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_n;
  logic                 rsp_err_q, rsp_err_n;
  logic                 grant_load, resp_load;

  // The port served last is masked for one IDLE cycle so its registered
  // deassert cannot be mistaken for a fresh request.
  assign eligible = req_valid_i & ~mask_q;

  xpu_rr_picker #(
    .N     (NUM_PORTS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (pick_oh)
  );

  always_comb begin
    pick_idx   = '0;
    pick_addr  = '0;
    pick_wen   = 1'b0;
    pick_wdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (pick_oh[k]) begin
        pick_idx   = PTR_W'(k);
        pick_addr  = req_addr_i[port_lsb(k, ADDR_W) +: ADDR_W];
        pick_wen   = req_wen_i[k];
        pick_wdata = req_wdata_i[port_lsb(k, DATA_W) +: DATA_W];
      end
    end
  end

  assign ptr_next = (grant_idx_q == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx_q + 1'b1;

  // A memory response arriving on the timeout cycle takes precedence.
  always_comb begin
    state_n    = state_q;
    grant_load = 1'b0;
    resp_load  = 1'b0;
    rsp_data_n = '0;
    rsp_err_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_n    = BUSY;
          grant_load = 1'b1;
        end
      end
      BUSY: begin
        if (mem_data_valid_i) begin
          state_n    = RESP;
          resp_load  = 1'b1;
          rsp_data_n = wen_q ? '0 : mem_data_i;
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
          state_n   = RESP;
          resp_load = 1'b1;
          rsp_err_n = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mask_q      <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        mask_q <= '0;
      end
      if (grant_load) begin
        grant_q     <= pick_oh;
        grant_idx_q <= pick_idx;
        addr_q      <= pick_addr;
        wen_q       <= pick_wen;
        wdata_q     <= pick_wdata;
      end
      if (state_q == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (resp_load) begin
        rsp_data_q <= rsp_data_n;
        rsp_err_q  <= rsp_err_n;
      end
      if (state_q == RESP) begin
        ptr_q  <= ptr_next;
        mask_q <= grant_q;
        cnt_q  <= '0;
      end
    end
  end

  assign mem_req_valid_o = (state_q == BUSY);
  assign mem_addr_o      = (state_q == BUSY) ? addr_q  : '0;
  assign mem_wen_o       = (state_q == BUSY) ? wen_q   : 1'b0;
  assign mem_wdata_o     = (state_q == BUSY) ? wdata_q : '0;
  assign grant_o         = ((state_q == BUSY) || (state_q == RESP)) ? grant_q : '0;
  assign rsp_valid_o     = (state_q == RESP) ? grant_q : '0;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_err_o       = rsp_err_q;

endmodule

// File: tb/tb_xpu_mem_arbiter.sv
// Scoreboard bench for xpu_mem_arbiter: a 2-port instance with a 4-cycle
// timeout and a 4-port instance with the timeout disabled.
module tb_xpu_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]      req_valid2, req_wen2, rsp_valid2, grant2;
  logic [2*AW-1:0] req_addr2;
  logic [2*DW-1:0] req_wdata2;
  logic [DW-1:0]   rsp_data2, mem_wdata2, mem_rdata2;
  logic [AW-1:0]   mem_addr2;
  logic            rsp_err2, mem_req2, mem_wen2, mem_dv2;

  logic [3:0]      req_valid4, req_wen4, rsp_valid4, grant4;
  logic [4*AW-1:0] req_addr4;
  logic [4*DW-1:0] req_wdata4;
  logic [DW-1:0]   rsp_data4, mem_wdata4, mem_rdata4;
  logic [AW-1:0]   mem_addr4;
  logic            rsp_err4, mem_req4, mem_wen4, mem_dv4;

  xpu_mem_arbiter #(
    .NUM_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4), .CNT_W(8)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid2), .req_addr_i(req_addr2), .req_wen_i(req_wen2), .req_wdata_i(req_wdata2),
    .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2), .rsp_err_o(rsp_err2),
    .mem_req_valid_o(mem_req2), .mem_addr_o(mem_addr2), .mem_wen_o(mem_wen2), .mem_wdata_o(mem_wdata2),
    .mem_data_valid_i(mem_dv2), .mem_data_i(mem_rdata2), .grant_o(grant2)
  );

  xpu_mem_arbiter #(
    .NUM_PORTS(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(0), .CNT_W(8)
  ) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid4), .req_addr_i(req_addr4), .req_wen_i(req_wen4), .req_wdata_i(req_wdata4),
    .rsp_valid_o(rsp_valid4), .rsp_data_o(rsp_data4), .rsp_err_o(rsp_err4),
    .mem_req_valid_o(mem_req4), .mem_addr_o(mem_addr4), .mem_wen_o(mem_wen4), .mem_wdata_o(mem_wdata4),
    .mem_data_valid_i(mem_dv4), .mem_data_i(mem_rdata4), .grant_o(grant4)
  );

  exp_t q2[$];
  exp_t q4[$];
  exp_t e2, e4;
  logic [1:0] oh2;
  logic [3:0] oh4;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  int  lat2 = 1, busy2 = 0, lat4 = 1, busy4 = 0;
  bit  silent2 = 1'b0;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return a ^ 64'hDEAD_BEEF_8000_0011;
  endfunction

  task automatic expect2(input int port, input logic [DW-1:0] data, input logic err);
    exp_t e;
    e.port = port; e.data = data; e.err = err;
    q2.push_back(e);
  endtask

  task automatic expect4(input int port, input logic [DW-1:0] data, input logic err);
    exp_t e;
    e.port = port; e.data = data; e.err = err;
    q4.push_back(e);
  endtask

  // Memory models: respond on the lat-th BUSY cycle of each transaction.
  task automatic cycle2();
    @(negedge clk);
    if (mem_req2 === 1'b1) begin
      busy2++;
      mem_dv2    = (!silent2 && busy2 == lat2);
      mem_rdata2 = mem_model(mem_addr2);
    end else begin
      busy2   = 0;
      mem_dv2 = 1'b0;
    end
  endtask

  task automatic cycle4();
    @(negedge clk);
    if (mem_req4 === 1'b1) begin
      busy4++;
      mem_dv4    = (busy4 == lat4);
      mem_rdata4 = mem_model(mem_addr4);
    end else begin
      busy4   = 0;
      mem_dv4 = 1'b0;
    end
  endtask

  // Every response pulse is popped against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid2 !== 2'b00) begin
        n_checks++;
        if (q2.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL rsp2_unexpected: got rsp_valid=%b, required no response", rsp_valid2);
        end else begin
          e2 = q2.pop_front();
          oh2 = '0;
          oh2[e2.port] = 1'b1;
          if (rsp_valid2 !== oh2 || rsp_data2 !== e2.data || rsp_err2 !== e2.err) begin
            n_fail++;
            $display("[TB] FAIL rsp2_scoreboard: got valid=%b data=%h err=%b, required valid=%b data=%h err=%b",
                     rsp_valid2, rsp_data2, rsp_err2, oh2, e2.data, e2.err);
          end
        end
      end
      if (rsp_valid4 !== 4'b0000) begin
        n_checks++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL rsp4_unexpected: got rsp_valid=%b, required no response", rsp_valid4);
        end else begin
          e4 = q4.pop_front();
          oh4 = '0;
          oh4[e4.port] = 1'b1;
          if (rsp_valid4 !== oh4 || rsp_data4 !== e4.data || rsp_err4 !== e4.err) begin
            n_fail++;
            $display("[TB] FAIL rsp4_scoreboard: got valid=%b data=%h err=%b, required valid=%b data=%h err=%b",
                     rsp_valid4, rsp_data4, rsp_err4, oh4, e4.data, e4.err);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    req_valid2 = '0; req_wen2 = '0; req_addr2 = '0; req_wdata2 = '0;
    req_valid4 = '0; req_wen4 = '0; req_addr4 = '0; req_wdata4 = '0;
    mem_dv2 = 1'b0; mem_rdata2 = '0; mem_dv4 = 1'b0; mem_rdata4 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_req2, mem_wen2, grant2, rsp_valid2, rsp_err2} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl2: got %b, required 0", {mem_req2, mem_wen2, grant2, rsp_valid2, rsp_err2});
    end
    n_checks++;
    if ({mem_addr2, mem_wdata2, rsp_data2} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data2: got addr=%h wdata=%h rdata=%h, required 0", mem_addr2, mem_wdata2, rsp_data2);
    end
    n_checks++;
    if ({mem_req4, grant4, rsp_valid4, rsp_err4, rsp_data4} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_out4: got req=%b grant=%b rsp=%b err=%b data=%h, required 0",
               mem_req4, grant4, rsp_valid4, rsp_err4, rsp_data4);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    // A stray memory strobe while idle must be ignored.
    @(negedge clk);
    mem_dv2 = 1'b1; mem_rdata2 = '1;
    @(negedge clk);
    mem_dv2 = 1'b0;
    n_checks++;
    if (mem_req2 !== 1'b0 || grant2 !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL idle_strobe_state: got req=%b grant=%b, required 0/00", mem_req2, grant2);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_data2 !== '0 || rsp_valid2 !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL idle_strobe_rsp: got data=%h valid=%b, required 0/00", rsp_data2, rsp_valid2);
    end
  endtask

  task automatic test_single_port();
    lat2 = 1; silent2 = 1'b0;
    cycle2();
    req_addr2[AW +: AW] = 64'h8000_0010;
    req_wen2[1]   = 1'b0;
    req_valid2[1] = 1'b1;
    expect2(1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    cycle2();
    n_checks++;
    if (mem_req2 !== 1'b1 || mem_addr2 !== 64'h8000_0010 || grant2 !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL single_t1: got req=%b addr=%h grant=%b, required 1/80000010/10", mem_req2, mem_addr2, grant2);
    end
    cycle2();
    n_checks++;
    if (rsp_valid2 !== 2'b10 || rsp_data2 !== 64'hDEAD_BEEF_0000_0001 || rsp_err2 !== 1'b0 || mem_req2 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_t2: got rsp=%b data=%h err=%b req=%b, required 10/deadbeef00000001/0/0",
               rsp_valid2, rsp_data2, rsp_err2, mem_req2);
    end
    req_valid2[1] = 1'b0;
    cycle2();
    n_checks++;
    if (rsp_valid2 !== 2'b00 || grant2 !== 2'b00 || rsp_data2 !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("[TB] FAIL single_t3: got rsp=%b grant=%b data=%h, required 00/00/held", rsp_valid2, grant2, rsp_data2);
    end
  endtask

  task automatic test_contention();
    int nrsp = 0, ngrant = 0;
    logic [1:0] last_rsp = 2'b00;
    logic [1:0] exp_g;
    lat2 = 3;
    req_addr2 = {64'h0000_0000_0000_2000, 64'h0000_0000_0000_1000};
    req_wen2  = 2'b00;
    for (int i = 0; i < 4; i++) begin
      expect2(i % 2, mem_model((i % 2 == 0) ? 64'h1000 : 64'h2000), 1'b0);
    end
    req_valid2 = 2'b11;
    for (int c = 0; c < 80; c++) begin
      cycle2();
      if (mem_req2 === 1'b1 && busy2 == 1) begin
        exp_g = (ngrant % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++;
        if (grant2 !== exp_g) begin
          n_fail++;
          $display("[TB] FAIL contention_grant%0d: got %b, required %b", ngrant, grant2, exp_g);
        end
        ngrant++;
      end
      if (rsp_valid2 !== 2'b00) begin
        n_checks++;
        if (rsp_valid2 === last_rsp) begin
          n_fail++;
          $display("[TB] FAIL contention_repeat: got %b twice, required alternation", rsp_valid2);
        end
        last_rsp = rsp_valid2;
        nrsp++;
        if (nrsp == 4) begin
          req_valid2 = 2'b00;
          break;
        end
      end
    end
    n_checks++;
    if (nrsp != 4 || ngrant != 4) begin
      n_fail++;
      $display("[TB] FAIL contention_count: got rsp=%0d grants=%0d, required 4/4", nrsp, ngrant);
    end
    repeat (2) cycle2();
  endtask

  task automatic test_write();
    int nbusy = 0;
    bit done = 1'b0;
    lat2 = 3;
    req_addr2[0 +: AW]  = 64'h100;
    req_wdata2[0 +: DW] = 64'h55AA;
    req_wen2[0]   = 1'b1;
    req_valid2[0] = 1'b1;
    expect2(0, '0, 1'b0);
    for (int c = 0; c < 30 && !done; c++) begin
      cycle2();
      if (mem_req2 === 1'b1) begin
        nbusy++;
        n_checks++;
        if (mem_wen2 !== 1'b1 || mem_wdata2 !== 64'h55AA || mem_addr2 !== 64'h100) begin
          n_fail++;
          $display("[TB] FAIL write_payload: got wen=%b wdata=%h addr=%h, required 1/55aa/100", mem_wen2, mem_wdata2, mem_addr2);
        end
      end
      if (rsp_valid2 !== 2'b00) begin
        req_valid2[0] = 1'b0;
        req_wen2[0]   = 1'b0;
        done = 1'b1;
      end
    end
    n_checks++;
    if (!done || nbusy != 3) begin
      n_fail++;
      $display("[TB] FAIL write_latency: got done=%b busy=%0d, required 1/3", done, nbusy);
    end
    repeat (2) cycle2();
  endtask

  task automatic test_timeout();
    int nbusy;
    bit done;
    // Silent memory, requester drops its request mid-transaction.
    silent2 = 1'b1;
    nbusy = 0; done = 1'b0;
    req_addr2[AW +: AW] = 64'h3000;
    req_valid2[1] = 1'b1;
    expect2(1, '0, 1'b1);
    for (int c = 0; c < 30 && !done; c++) begin
      cycle2();
      if (mem_req2 === 1'b1) begin
        nbusy++;
        req_valid2[1] = 1'b0;
      end
      if (rsp_valid2 !== 2'b00) done = 1'b1;
    end
    n_checks++;
    if (!done || nbusy != 4) begin
      n_fail++;
      $display("[TB] FAIL timeout_err_busy: got done=%b busy=%0d, required 1/4", done, nbusy);
    end
    repeat (2) cycle2();
    // Late response on the timeout cycle wins.
    silent2 = 1'b0; lat2 = 4;
    nbusy = 0; done = 1'b0;
    req_addr2[0 +: AW] = 64'h4000;
    req_valid2[0] = 1'b1;
    expect2(0, mem_model(64'h4000), 1'b0);
    for (int c = 0; c < 30 && !done; c++) begin
      cycle2();
      if (mem_req2 === 1'b1) nbusy++;
      if (rsp_valid2 !== 2'b00) begin
        req_valid2[0] = 1'b0;
        done = 1'b1;
        n_checks++;
        if (rsp_err2 !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL timeout_late_err: got %b, required 0", rsp_err2);
        end
      end
    end
    n_checks++;
    if (!done || nbusy != 4) begin
      n_fail++;
      $display("[TB] FAIL timeout_late_busy: got done=%b busy=%0d, required 1/4", done, nbusy);
    end
    repeat (2) cycle2();
  endtask

  task automatic test_reset_mid_busy();
    bit seen = 1'b0;
    bit done = 1'b0;
    silent2 = 1'b1;
    req_addr2[0 +: AW] = 64'h5000;
    req_valid2[0] = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle2();
      if (mem_req2 === 1'b1 && busy2 == 2) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL rst_busy_reach: got busy=%0d, required 2", busy2);
    end
    rst = 1'b1;
    cycle2();
    n_checks++;
    if ({mem_req2, mem_wen2, grant2, rsp_valid2, rsp_err2} !== 7'b0 || {mem_addr2, mem_wdata2, rsp_data2} !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_busy_outputs: got req=%b grant=%b rsp=%b addr=%h data=%h, required all 0",
               mem_req2, grant2, rsp_valid2, mem_addr2, rsp_data2);
    end
    rst = 1'b0;
    req_valid2 = 2'b00;
    silent2 = 1'b0; lat2 = 1;
    for (int c = 0; c < 3; c++) begin
      cycle2();
      n_checks++;
      if (rsp_valid2 !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL rst_busy_no_rsp: got %b, required 00", rsp_valid2);
      end
    end
    // Pointer back at 0: port 0 wins a simultaneous request.
    req_addr2 = {64'h0000_0000_0000_6000, 64'h0000_0000_0000_5000};
    req_valid2 = 2'b11;
    expect2(0, mem_model(64'h5000), 1'b0);
    for (int c = 0; c < 20 && !done; c++) begin
      cycle2();
      if (mem_req2 === 1'b1 && busy2 == 1) begin
        n_checks++;
        if (grant2 !== 2'b01) begin
          n_fail++;
          $display("[TB] FAIL rst_busy_ptr: got grant=%b, required 01", grant2);
        end
      end
      if (rsp_valid2 !== 2'b00) begin
        req_valid2 = 2'b00;
        done = 1'b1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL rst_busy_after: got no response, required one");
    end
    repeat (2) cycle2();
  endtask

  task automatic test_four_port();
    int nrsp = 0, ngrant = 0;
    bit done = 1'b0;
    logic [3:0]    exp_g;
    logic [AW-1:0] exp_a;
    lat4 = 2;
    req_addr4[1*AW +: AW] = 64'h10;
    req_addr4[3*AW +: AW] = 64'h30;
    req_valid4[1] = 1'b1;
    expect4(1, mem_model(64'h10), 1'b0);
    for (int c = 0; c < 20 && !done; c++) begin
      cycle4();
      if (rsp_valid4 !== 4'b0000) begin
        req_valid4[1] = 1'b0;
        done = 1'b1;
      end
    end
    repeat (2) cycle4();
    // Pointer now 2: port 3 first, then port 1.
    expect4(3, mem_model(64'h30), 1'b0);
    expect4(1, mem_model(64'h10), 1'b0);
    req_valid4 = 4'b1010;
    for (int c = 0; c < 40 && nrsp < 2; c++) begin
      cycle4();
      if (mem_req4 === 1'b1 && busy4 == 1) begin
        exp_g = (ngrant == 0) ? 4'b1000 : 4'b0010;
        exp_a = (ngrant == 0) ? 64'h30 : 64'h10;
        n_checks++;
        if (grant4 !== exp_g || mem_addr4 !== exp_a) begin
          n_fail++;
          $display("[TB] FAIL four_port_grant%0d: got grant=%b addr=%h, required %b/%h", ngrant, grant4, mem_addr4, exp_g, exp_a);
        end
        ngrant++;
      end
      if (rsp_valid4 !== 4'b0000) begin
        req_valid4 = req_valid4 & ~rsp_valid4;
        nrsp++;
      end
    end
    n_checks++;
    if (!done || nrsp != 2 || ngrant != 2) begin
      n_fail++;
      $display("[TB] FAIL four_port_count: got first=%b rsp=%0d grants=%0d, required 1/2/2", done, nrsp, ngrant);
    end
    repeat (2) cycle4();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_port();
    test_contention();
    test_write();
    test_timeout();
    test_reset_mid_busy();
    test_four_port();
    n_checks++;
    if (q2.size() != 0 || q4.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q2.size(), q4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xpu_mem_arbiter.md
Name: xpu_mem_arbiter

Overview:
- Parametrised N-port arbiter merging the core's level-handshake cache request ports (icache, dcache, future PTW/DMA) onto a single memory-side port of the same protocol.
- Round-robin grant, one outstanding transaction, per-port response steering, optional response-timeout with error flag.
- Sits between the XPU core ports and the shared memory/bus model.

Parameters:
- NUM_PORTS, 2, number of requester ports (>=2)
- ADDR_W, 64, address width
- DATA_W, 64, data width
- TIMEOUT_CYC, 255, max BUSY cycles before error response; 0 disables timeout
- CNT_W, 8, timeout counter width (must hold TIMEOUT_CYC)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  NUM_PORTS  per-port request, level, held until served
- req_addr_i  in  NUM_PORTS*ADDR_W  packed per-port address, port k at [k*ADDR_W +: ADDR_W]
- req_wen_i  in  NUM_PORTS  per-port write enable
- req_wdata_i  in  NUM_PORTS*DATA_W  packed per-port write data
- rsp_valid_o  out  NUM_PORTS  one-cycle response pulse to the served port
- rsp_data_o  out  DATA_W  read data (shared; qualified by rsp_valid_o)
- rsp_err_o  out  1  response is a timeout error (qualified by rsp_valid_o)
- mem_req_valid_o  out  1  memory-side request
- mem_addr_o  out  ADDR_W  memory-side address
- mem_wen_o  out  1  memory-side write enable
- mem_wdata_o  out  DATA_W  memory-side write data
- mem_data_valid_i  in  1  memory response strobe
- mem_data_i  in  DATA_W  memory read data
- grant_o  out  NUM_PORTS  one-hot current owner (debug/diff)

Behaviour:
- Reset: state IDLE, all outputs 0, rr pointer = 0 (port 0 highest priority), mask = 0, counter = 0.
- States: IDLE, BUSY, RESP.
- IDLE: eligible = req_valid_i & ~mask. If none, stay. Else pick first eligible port searching from rr pointer upward with wrap; latch its addr/wen/wdata and one-hot grant; clear mask; go BUSY.
- BUSY: mem_req_valid_o=1, mem_* driven from latched payload (stable throughout). Counter increments each cycle.
  - mem_data_valid_i=1: latch mem_data_i (0 if write), err=0, go RESP.
  - Else if TIMEOUT_CYC!=0 and counter == TIMEOUT_CYC-1: latch data=0, err=1, go RESP. mem_req_valid_o falls in RESP.
  - mem_data_valid_i and timeout in same cycle: response wins, err=0.
- RESP: rsp_valid_o[granted]=1 for exactly one cycle, rsp_data_o/rsp_err_o valid; rr pointer <= granted+1 (wrap at NUM_PORTS); mask <= grant (served port ineligible for the next IDLE cycle only, absorbing requester's registered deassert); counter <= 0; go IDLE.
- Outside RESP rsp_valid_o=0, rsp_data_o/rsp_err_o hold last value. grant_o nonzero only in BUSY/RESP.
- Minimum latency: request in IDLE cycle t -> mem_req_valid_o at t+1 -> with same-cycle memory response, rsp_valid_o at t+2 -> IDLE at t+3.
- Requester dropping req_valid_i while BUSY: transaction completes anyway; response still pulsed.
- mem_data_valid_i outside BUSY: ignored.
- rst asserted in any state: next cycle is reset state; in-flight transaction dropped, no response.
- Fairness: every continuously requesting port served within NUM_PORTS grants.

Decomposition:
- Shared package xpu_mem_pkg: state encoding (IDLE/BUSY/RESP), default widths, packed-port slice helpers.
- One sub-module natural: xpu_rr_picker (combinational, request vector + pointer -> one-hot winner); FSM, payload latch and counter in the top arbiter.

Test Plan:
- Single port: port1 reads addr 0x8000_0010, memory returns 0xDEAD_BEEF_0000_0001 same cycle -> mem_req_valid_o at t+1, rsp_valid_o=2'b10 at t+2 with that data, err=0.
- Contention: both ports request continuously, memory 3-cycle latency -> grants alternate 0,1,0,1; no port served twice consecutively; each sees exactly one rsp pulse per transaction.
- Write: port0 wen=1, addr 0x100, wdata 0x55AA -> mem_wen_o=1, mem_wdata_o=0x55AA stable all BUSY cycles; rsp_data_o=0.
- Timeout: TIMEOUT_CYC=4, memory silent -> BUSY exactly 4 cycles, rsp_valid_o pulse with err=1, data=0; simultaneous late response on cycle 4 -> err=0.
- Reset mid-BUSY: assert rst during BUSY -> next cycle all outputs 0, no rsp pulse, rr pointer 0.
- NUM_PORTS=4, ports 1 and 3 requesting, pointer at 2 -> port 3 granted first, then port 1.
